alignment_pe: RTL and testbench
===============================

# alignment_pe

Single systolic processing element of the linear alignment array, directly downstream of `blosum_compare`. Holds one `seq1` residue, takes `seq2` residues streamed from its left neighbour, scores each pair through an internal `blosum_compare` instance, and computes one dynamic-programming cell per valid beat with a linear gap penalty. It forwards the residue and the new cell score to the next element, and emits a traceback pointer per cell plus a best-score summary at end of pass.

## Interface
- `GAP_PENALTY`, 4: positive linear gap cost, subtracted per gap.
- `MAX_LEN`, 1024: maximum `seq2` length per pass.
- `SCORE_W`, 16: signed score width. `blosum_compare.score` is interpreted as two's-complement.
- One clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous active-high reset.
- `load_en`  in  1  latch `load_residue` and `boundary_h`. Honoured only in IDLE or LOADED.
- `load_residue`  in  `protein_base`  this element's `seq1` residue.
- `boundary_h`  in  SCORE_W  H[i][0] for this row.
- `start`  in  1  begin a pass. Honoured only in LOADED.
- `seq2_len`  in  11  columns in the pass (1..MAX_LEN), sampled with `start`.
- `in_valid`  in  1  beat qualifier from the left neighbour.
- `in_residue`  in  `protein_base`  `seq2[j]`.
- `in_h`  in  SCORE_W  H[i-1][j] from the upstream row.
- `out_valid`  out  1  registered copy of an accepted beat.
- `out_residue`  out  `protein_base`  `in_residue` delayed one cycle.
- `out_h`  out  SCORE_W  H[i][j].
- `out_dir`  out  2  traceback: 00 diag, 01 up, 10 left, 11 zero.
- `done`  out  1  one-cycle pulse on the last column.
- `best_score`  out  SCORE_W  pass summary.
- `best_col`  out  11  column index (1-based) of `best_score`.

## Operation
- States:
  - IDLE → LOADED on `load_en`.
  - LOADED → RUN on `start`. While in LOADED, `load_en` reloads the residue.
  - RUN → LOADED on the beat where `col == seq2_len`. `done` is asserted with that beat's outputs.
- On `start`, registers initialise as follows:
  - `col` = 0.
  - `left_r` = `boundary_h`.
  - `diag_r` = `boundary_h + GAP_PENALTY`, i.e. H[i-1][0].
  - `best_score` = 0 and `best_col` = 0 (local build).
- Each accepted beat (RUN and `in_valid`):
  - diag = `diag_r` + blosum(`seq1_r`, `in_residue`).
  - up = `in_h` − GAP_PENALTY.
  - left = `left_r` − GAP_PENALTY.
  - H = max of diag, up, left, with ties resolved diag > up > left.
  - Register H into `out_h` and `left_r`; register `in_h` into `diag_r`; increment `col`.
- All adds and subtracts saturate at −2^(SCORE_W−1) and 2^(SCORE_W−1)−1.
- `in_valid` low in RUN is a stall: no state changes, and `out_valid` is 0 next cycle.
- `in_valid` outside RUN is ignored: no output.
- `start` in RUN is ignored. `load_en` in RUN is ignored.
- `reset` at any time, including mid-RUN, returns to IDLE. All outputs go to 0 and `seq1_r` to `A`.
- Global build: `best_score` and `best_col` take the final H and `seq2_len` on the `done` beat.

## Timing
- Outputs are registered, with one-cycle latency from an accepted beat. The `blosum_compare` lookup is in the same cycle as the max.
- `done` is high in the same cycle as the last `out_valid`.
- Reset values: `out_valid`, `done`, `out_h`, `out_dir`, `best_score`, `best_col` all 0; `out_residue` = `A`.
- Throughput: one cell per cycle with no required bubbles.

## Configuration
- `LOCAL_ALIGN_EN` defined (Smith–Waterman):
  - `start` forces `left_r` = `diag_r` = 0, ignoring `boundary_h`.
  - H is clamped at 0, with priority diag > up > left > zero. `out_dir` = 11 only when zero strictly wins.
  - `best_score` and `best_col` track the running max, with the first occurrence kept on ties.
- Undefined (Needleman–Wunsch): boundary initialisation as above, no clamp, and `out_dir` never equals 11.

## Test plan
- Reset: hold `reset` 2 cycles, including mid-RUN → IDLE, all outputs 0, a following `start` ignored until `load_en`.
- Global, GAP 4, residue A, `boundary_h` −4, `seq2_len` 3, stream A,A,A with `in_h` −4,−8,−12 → `out_h` 4,0,−4, `out_dir` 00,00,00, `done` on the third beat, `best_score` −4, `best_col` 3.
- Same as previous with 1–3 idle cycles between beats → identical output values, `col` not advancing on stalls, `done` only on the third valid beat.
- Local, residue A, stream W,A,W with `in_h` 0,0,0 → `out_h` 0,4,0, `out_dir` 11,00,10, `best_score` 4, `best_col` 2.
- Saturation (global), residue A, `boundary_h` 0, `seq2_len` 2, `in_h` 32767,32767 → `out_h` 32763 (dir 01), then 32767 (dir 00, clamped).
- `start` and `load_en` pulsed mid-RUN → ignored; pass completes with unchanged results.

Source files
------------

// File: rtl/alignment_pe_if.sv
// Residue encoding shared by the alignment array, plus the alignment_pe port bundle.
// The master side feeds a PE and receives its outputs; the slave side is the PE.
package alignment_pkg;
  typedef enum logic [4:0] {
    AA_A, AA_R, AA_N, AA_D, AA_C, AA_Q, AA_E, AA_G, AA_H, AA_I,
    AA_L, AA_K, AA_M, AA_F, AA_P, AA_S, AA_T, AA_W, AA_Y, AA_V
  } protein_base;
endpackage

interface alignment_pe_if #(
  parameter int SCORE_W = 16
);
  import alignment_pkg::*;

  logic                      load_en;
  protein_base               load_residue;
  logic signed [SCORE_W-1:0] boundary_h;
  logic                      start;
  logic [10:0]               seq2_len;
  logic                      in_valid;
  protein_base               in_residue;
  logic signed [SCORE_W-1:0] in_h;
  logic                      out_valid;
  protein_base               out_residue;
  logic signed [SCORE_W-1:0] out_h;
  logic [1:0]                out_dir;
  logic                      done;
  logic signed [SCORE_W-1:0] best_score;
  logic [10:0]               best_col;

  modport master (
    output load_en, load_residue, boundary_h, start, seq2_len,
           in_valid, in_residue, in_h,
    input  out_valid, out_residue, out_h, out_dir, done, best_score, best_col
  );

  modport slave (
    input  load_en, load_residue, boundary_h, start, seq2_len,
           in_valid, in_residue, in_h,
    output out_valid, out_residue, out_h, out_dir, done, best_score, best_col
  );
endinterface

// File: rtl/alignment_pe.sv
// One systolic DP cell of the linear alignment array, with its BLOSUM62 scorer.
// Defining LOCAL_ALIGN_EN selects Smith-Waterman (zero clamp, running best); otherwise Needleman-Wunsch.
module blosum_compare
  import alignment_pkg::*;
(
  input  protein_base a,
  input  protein_base b,
  output logic [4:0]  score
);
  localparam int BLOSUM62 [20][20] = '{
    '{ 4,-1,-2,-2, 0,-1,-1, 0,-2,-1,-1,-1,-1,-2,-1, 1, 0,-3,-2, 0},
    '{-1, 5, 0,-2,-3, 1, 0,-2, 0,-3,-2, 2,-1,-3,-2,-1,-1,-3,-2,-3},
    '{-2, 0, 6, 1,-3, 0, 0, 0, 1,-3,-3, 0,-2,-3,-2, 1, 0,-4,-2,-3},
    '{-2,-2, 1, 6,-3, 0, 2,-1,-1,-3,-4,-1,-3,-3,-1, 0,-1,-4,-3,-3},
    '{ 0,-3,-3,-3, 9,-3,-4,-3,-3,-1,-1,-3,-1,-2,-3,-1,-1,-2,-2,-1},
    '{-1, 1, 0, 0,-3, 5, 2,-2, 0,-3,-2, 1, 0,-3,-1, 0,-1,-2,-1,-2},
    '{-1, 0, 0, 2,-4, 2, 5,-2, 0,-3,-3, 1,-2,-3,-1, 0,-1,-3,-2,-2},
    '{ 0,-2, 0,-1,-3,-2,-2, 6,-2,-4,-4,-2,-3,-3,-2, 0,-2,-2,-3,-3},
    '{-2, 0, 1,-1,-3, 0, 0,-2, 8,-3,-3,-1,-2,-1,-2,-1,-2,-2, 2,-3},
    '{-1,-3,-3,-3,-1,-3,-3,-4,-3, 4, 2,-3, 1, 0,-3,-2,-1,-3,-1, 3},
    '{-1,-2,-3,-4,-1,-2,-3,-4,-3, 2, 4,-2, 2, 0,-3,-2,-1,-2,-1, 1},
    '{-1, 2, 0,-1,-3, 1, 1,-2,-1,-3,-2, 5,-1,-3,-1, 0,-1,-3,-2,-2},
    '{-1,-1,-2,-3,-1, 0,-2,-3,-2, 1, 2,-1, 5, 0,-2,-1,-1,-1,-1, 1},
    '{-2,-3,-3,-3,-2,-3,-3,-3,-1, 0, 0,-3, 0, 6,-4,-2,-2, 1, 3,-1},
    '{-1,-2,-2,-1,-3,-1,-1,-2,-2,-3,-3,-1,-2,-4, 7,-1,-1,-4,-3,-2},
    '{ 1,-1, 1, 0,-1, 0, 0, 0,-1,-2,-2, 0,-1,-2,-1, 4, 1,-3,-2,-2},
    '{ 0,-1, 0,-1,-1,-1,-1,-2,-2,-1,-1,-1,-1,-2,-1, 1, 5,-2,-2, 0},
    '{-3,-3,-4,-4,-2,-2,-3,-2,-2,-3,-2,-3,-1, 1,-4,-3,-2,11, 2,-3},
    '{-2,-2,-2,-3,-2,-1,-2,-3, 2,-1,-1,-2,-1, 3,-3,-2,-2, 2, 7,-1},
    '{ 0,-3,-3,-3,-1,-2,-2,-3,-3, 3, 1,-2, 1,-1,-2,-2, 0,-3,-1, 4}
  };

  logic [4:0] ai;
  logic [4:0] bi;

  // Encodings 20..31 are not residues; they score 0 rather than reading past the table.
  always_comb begin
    ai    = a;
    bi    = b;
    score = '0;
    if (ai < 5'd20 && bi < 5'd20) score = 5'(BLOSUM62[ai][bi]);
  end
endmodule

module alignment_pe
  import alignment_pkg::*;
#(
  parameter int GAP_PENALTY = 4,
  parameter int MAX_LEN     = 1024,
  parameter int SCORE_W     = 16
) (
  input logic           clk,
  input logic           reset,
  alignment_pe_if.slave pe
);
`ifdef LOCAL_ALIGN_EN
  localparam bit LOCAL = 1'b1;
`else
  localparam bit LOCAL = 1'b0;
`endif

  localparam logic signed [SCORE_W-1:0] S_MAX    = {1'b0, {(SCORE_W-1){1'b1}}};
  localparam logic signed [SCORE_W-1:0] S_MIN    = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic signed [SCORE_W-1:0] POS_GAP  = SCORE_W'(GAP_PENALTY);
  localparam logic signed [SCORE_W-1:0] NEG_GAP  = SCORE_W'(-GAP_PENALTY);
  localparam logic [1:0]                DIR_DIAG = 2'b00;
  localparam logic [1:0]                DIR_UP   = 2'b01;
  localparam logic [1:0]                DIR_LEFT = 2'b10;
  localparam logic [1:0]                DIR_ZERO = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LOADED, S_RUN} state_t;

  function automatic logic signed [SCORE_W-1:0] sat_add(
    input logic signed [SCORE_W-1:0] a,
    input logic signed [SCORE_W-1:0] b
  );
    logic [SCORE_W:0] s;
    s = {a[SCORE_W-1], a} + {b[SCORE_W-1], b};
    if (s[SCORE_W] != s[SCORE_W-1]) sat_add = s[SCORE_W] ? S_MIN : S_MAX;
    else                            sat_add = s[SCORE_W-1:0];
  endfunction

  state_t                    state_q, state_d;
  protein_base               seq1_q, seq1_d;
  logic signed [SCORE_W-1:0] bound_q, bound_d;
  logic [10:0]               len_q, len_d;
  logic [10:0]               col_q, col_d;
  logic signed [SCORE_W-1:0] left_q, left_d;
  logic signed [SCORE_W-1:0] diag_q, diag_d;
  logic                      out_vld_q, out_vld_d;
  protein_base               out_res_q, out_res_d;
  logic signed [SCORE_W-1:0] out_h_q, out_h_d;
  logic [1:0]                out_dir_q, out_dir_d;
  logic                      done_q, done_d;
  logic signed [SCORE_W-1:0] best_q, best_d;
  logic [10:0]               best_col_q, best_col_d;

  logic [4:0]                bl_score;
  logic signed [SCORE_W-1:0] bl_ext;
  logic signed [SCORE_W-1:0] cand_diag, cand_up, cand_left, cand_h;
  logic [1:0]                cand_dir;

  blosum_compare u_blosum (
    .a     (seq1_q),
    .b     (pe.in_residue),
    .score (bl_score)
  );

  always_comb begin
    state_d    = state_q;
    seq1_d     = seq1_q;
    bound_d    = bound_q;
    len_d      = len_q;
    col_d      = col_q;
    left_d     = left_q;
    diag_d     = diag_q;
    out_vld_d  = 1'b0;
    out_res_d  = out_res_q;
    out_h_d    = out_h_q;
    out_dir_d  = out_dir_q;
    done_d     = 1'b0;
    best_d     = best_q;
    best_col_d = best_col_q;

    bl_ext    = {{(SCORE_W-5){bl_score[4]}}, bl_score};
    cand_diag = sat_add(diag_q, bl_ext);
    cand_up   = sat_add(pe.in_h, NEG_GAP);
    cand_left = sat_add(left_q, NEG_GAP);

    // Strict compares keep the earlier candidate on ties: diag > up > left > zero.
    cand_h   = cand_diag;
    cand_dir = DIR_DIAG;
    if (cand_up > cand_h) begin
      cand_h   = cand_up;
      cand_dir = DIR_UP;
    end
    if (cand_left > cand_h) begin
      cand_h   = cand_left;
      cand_dir = DIR_LEFT;
    end
    if (LOCAL && cand_h[SCORE_W-1]) begin
      cand_h   = '0;
      cand_dir = DIR_ZERO;
    end

    case (state_q)
      S_IDLE: begin
        if (pe.load_en) begin
          seq1_d  = pe.load_residue;
          bound_d = pe.boundary_h;
          state_d = S_LOADED;
        end
      end
      S_LOADED: begin
        if (pe.start) begin
          state_d = S_RUN;
          len_d   = pe.seq2_len;
          col_d   = '0;
          if (LOCAL) begin
            left_d     = '0;
            diag_d     = '0;
            best_d     = '0;
            best_col_d = '0;
          end else begin
            left_d = bound_q;
            diag_d = sat_add(bound_q, POS_GAP);
          end
        end else if (pe.load_en) begin
          seq1_d  = pe.load_residue;
          bound_d = pe.boundary_h;
        end
      end
      S_RUN: begin
        if (pe.in_valid) begin
          col_d     = col_q + 11'd1;
          left_d    = cand_h;
          diag_d    = pe.in_h;
          out_vld_d = 1'b1;
          out_res_d = pe.in_residue;
          out_h_d   = cand_h;
          out_dir_d = cand_dir;
          if (LOCAL && cand_h > best_q) begin
            best_d     = cand_h;
            best_col_d = col_d;
          end
          if (col_d == len_q) begin
            done_d  = 1'b1;
            state_d = S_LOADED;
            if (!LOCAL) begin
              best_d     = cand_h;
              best_col_d = len_q;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      seq1_q     <= AA_A;
      bound_q    <= '0;
      len_q      <= '0;
      col_q      <= '0;
      left_q     <= '0;
      diag_q     <= '0;
      out_vld_q  <= 1'b0;
      out_res_q  <= AA_A;
      out_h_q    <= '0;
      out_dir_q  <= '0;
      done_q     <= 1'b0;
      best_q     <= '0;
      best_col_q <= '0;
    end else begin
      state_q    <= state_d;
      seq1_q     <= seq1_d;
      bound_q    <= bound_d;
      len_q      <= len_d;
      col_q      <= col_d;
      left_q     <= left_d;
      diag_q     <= diag_d;
      out_vld_q  <= out_vld_d;
      out_res_q  <= out_res_d;
      out_h_q    <= out_h_d;
      out_dir_q  <= out_dir_d;
      done_q     <= done_d;
      best_q     <= best_d;
      best_col_q <= best_col_d;
    end
  end

  assign pe.out_valid   = out_vld_q;
  assign pe.out_residue = out_res_q;
  assign pe.out_h       = out_h_q;
  assign pe.out_dir     = out_dir_q;
  assign pe.done        = done_q;
  assign pe.best_score  = best_q;
  assign pe.best_col    = best_col_q;
endmodule

// File: tb/tb_alignment_pe.sv
// Scoreboard bench for alignment_pe: expected cells are queued as beats are driven and popped on out_valid.
module tb_alignment_pe;
  import alignment_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alignment_pe_if #(.SCORE_W(16)) pe_if ();

  alignment_pe #(.GAP_PENALTY(4), .MAX_LEN(1024), .SCORE_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .pe    (pe_if)
  );

  typedef struct {
    int h;
    int dir;
    int done;
    int res;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (pe_if.out_valid) begin
        if (sb.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          e = sb.pop_front();
          check("out_h", int'(pe_if.out_h), e.h);
          check("out_dir", int'(pe_if.out_dir), e.dir);
          check("done", int'(pe_if.done), e.done);
          check("out_residue", int'(pe_if.out_residue), e.res);
        end
      end else if (pe_if.done) begin
        check("done_without_valid", 1, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input protein_base r, input int bh);
    pe_if.load_en      = 1'b1;
    pe_if.load_residue = r;
    pe_if.boundary_h   = 16'(bh);
    tick();
    pe_if.load_en = 1'b0;
  endtask

  task automatic start_pass(input int len);
    pe_if.start    = 1'b1;
    pe_if.seq2_len = 11'(len);
    tick();
    pe_if.start = 1'b0;
  endtask

  task automatic beat(input protein_base r, input int h, input int eh, input int edir, input int edone);
    exp_t e;
    e.h    = eh;
    e.dir  = edir;
    e.done = edone;
    e.res  = int'(r);
    sb.push_back(e);
    pe_if.in_valid   = 1'b1;
    pe_if.in_residue = r;
    pe_if.in_h       = 16'(h);
    tick();
    pe_if.in_valid = 1'b0;
  endtask

  task automatic finish_pass(input string tag, input int eb, input int ec);
    idle(2);
    check({tag, "_best_score"}, int'(pe_if.best_score), eb);
    check({tag, "_best_col"}, int'(pe_if.best_col), ec);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_out_valid"}, int'(pe_if.out_valid), 0);
    check({tag, "_done"}, int'(pe_if.done), 0);
    check({tag, "_out_h"}, int'(pe_if.out_h), 0);
    check({tag, "_out_dir"}, int'(pe_if.out_dir), 0);
    check({tag, "_best_score"}, int'(pe_if.best_score), 0);
    check({tag, "_best_col"}, int'(pe_if.best_col), 0);
    check({tag, "_out_residue"}, int'(pe_if.out_residue), int'(AA_A));
  endtask

  initial begin
    reset              = 1'b1;
    pe_if.load_en      = 1'b0;
    pe_if.load_residue = AA_A;
    pe_if.boundary_h   = '0;
    pe_if.start        = 1'b0;
    pe_if.seq2_len     = '0;
    pe_if.in_valid     = 1'b0;
    pe_if.in_residue   = AA_A;
    pe_if.in_h         = '0;
    idle(2);
    reset = 1'b0;
    check_outputs_zero("rst");

    // Reset mid-run, then start and beats in IDLE must produce nothing.
    load(AA_A, -4);
    start_pass(3);
    beat(AA_A, -4, 4, 0, 0);
    idle(1);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    check_outputs_zero("mid_rst");
    start_pass(3);
    for (int i = 0; i < 3; i++) begin
      pe_if.in_valid = 1'b1;
      pe_if.in_h     = 16'(-4 * (i + 1));
      tick();
    end
    pe_if.in_valid = 1'b0;
    idle(2);
    check("idle_no_out", int'(pe_if.out_valid), 0);
    check("idle_sb_empty", sb.size(), 0);

`ifdef LOCAL_ALIGN_EN
    load(AA_A, 0);
    start_pass(3);
    beat(AA_W, 0, 0, 3, 0);
    beat(AA_A, 0, 4, 0, 0);
    beat(AA_W, 0, 0, 2, 1);
    finish_pass("local", 4, 2);
`else
    load(AA_A, -4);
    start_pass(3);
    beat(AA_A, -4, 4, 0, 0);
    beat(AA_A, -8, 0, 0, 0);
    beat(AA_A, -12, -4, 0, 1);
    finish_pass("glob", -4, 3);

    // Mid-run start/load_en pulses, one on a stall cycle and one alongside a beat.
    start_pass(3);
    beat(AA_A, -4, 4, 0, 0);
    pe_if.start        = 1'b1;
    pe_if.seq2_len     = 11'd1;
    pe_if.load_en      = 1'b1;
    pe_if.load_residue = AA_W;
    pe_if.boundary_h   = 16'd100;
    tick();
    pe_if.start = 1'b0;
    beat(AA_A, -8, 0, 0, 0);
    pe_if.load_en = 1'b0;
    beat(AA_A, -12, -4, 0, 1);
    finish_pass("pulse", -4, 3);

    // No reload: an ignored mid-run load leaves residue A and boundary -4 in place.
    start_pass(3);
    beat(AA_A, -4, 4, 0, 0);
    idle($urandom_range(1, 3));
    beat(AA_A, -8, 0, 0, 0);
    idle($urandom_range(1, 3));
    beat(AA_A, -12, -4, 0, 1);
    finish_pass("stall", -4, 3);

    load(AA_A, 0);
    start_pass(2);
    beat(AA_A, 32767, 32763, 1, 0);
    beat(AA_A, 32767, 32767, 0, 1);
    finish_pass("sat", 32767, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
